// File: rtl/sram_pkg.sv
// Shared definitions for the 16-bit SRAM controller: state encoding,
// default timing and the SRAM pin widths.
package sram_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int DEF_WAIT_CYCLES = 5;
    localparam int DEF_BASE_ADDR   = 1024;
    localparam int SRAM_AW         = 18;
    localparam int SRAM_DW         = 16;
endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-access cycle counter; clear wins over enable, `last` flags the
// final cycle of a WAIT_CYCLES-long window.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign last = (cnt == CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two timed 16-bit SRAM accesses and holds
// `ready` low while the access is in flight so the pipeline can freeze.
module sram_controller
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);
    sram_state_t        state, next_state;
    logic               op_wr;
    logic [16:0]        word_q;
    logic [16:0]        word_next;
    logic [31:0]        wdata_q;
    logic               start;
    logic               cnt_en, cnt_clr, cnt_last;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;

    assign word_next = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign start     = (state == IDLE) && (wr_en || rd_en);
    // Counter restarts on every LOW/HIGH entry: held clear outside them and
    // cleared again on the final cycle of each half.
    assign cnt_clr   = ~cnt_en | cnt_last;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            op_wr   <= wr_en;
            word_q  <= word_next;
            wdata_q <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            read_data <= '0;
        else if (cnt_en && cnt_last && !op_wr) begin
            if (state == LOW)
                read_data[15:0]  <= SRAM_DQ;
            else
                read_data[31:16] <= SRAM_DQ;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        cnt_en     = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        dq_oe      = 1'b0;
        dq_out     = wdata_q[15:0];
        case (state)
            IDLE: begin
                ready = ~(wr_en | rd_en);
                if (wr_en || rd_en)
                    next_state = LOW;
            end
            LOW, HIGH: begin
                cnt_en    = 1'b1;
                SRAM_ADDR = {word_q, (state == HIGH)};
                if (op_wr) begin
                    dq_oe     = 1'b1;
                    dq_out    = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                    // Release WE one cycle early so data is held past the strobe.
                    SRAM_WE_N = cnt_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (cnt_last)
                    next_state = (state == LOW) ? HIGH : DONE;
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n;

    logic [15:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(5), .BASE_ADDR(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[3:0]] : 16'hzzzz;
    always @(posedge clk)
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, output int lat, output int we_lo,
                              output int oe_lo, output logic [31:0] rdat);
        wr_en = w; rd_en = r; address = a; write_data = d;
        lat = -1; we_lo = 0; oe_lo = 0; rdat = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (ready) begin
                lat  = c;
                rdat = read_data;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_we_lo;
        int          exp_oe_lo;
        int          lo_idx;
        logic        idle_after;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, we_lo, oe_lo;
        logic [31:0] rdat;

        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, 8, 0,  2, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF, 0, 10, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h12345678, 32'hDEADBEEF, 8, 0,  0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'h12345678, 0, 10, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678, 8, 0,  4, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'hCAFEF00D, 0, 10, 0, 1'b1};

        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset we_n", {31'b0, sram_we_n}, 32'd1);
        chk("reset oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("reset addr", {14'b0, sram_addr}, 32'd0);
        chk("reset read_data", read_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                       lat, we_lo, oe_lo, rdat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd11);
            chk($sformatf("v%0d we_n low cycles", i), 32'(we_lo), 32'(vecs[i].exp_we_lo));
            chk($sformatf("v%0d oe_n low cycles", i), 32'(oe_lo), 32'(vecs[i].exp_oe_lo));
            chk($sformatf("v%0d read_data", i), rdat, vecs[i].exp_rdata);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d mem lo", i), {16'b0, mem[vecs[i].lo_idx]},
                    {16'b0, vecs[i].wdata[15:0]});
                chk($sformatf("v%0d mem hi", i), {16'b0, mem[vecs[i].lo_idx + 1]},
                    {16'b0, vecs[i].wdata[31:16]});
            end
            if (vecs[i].idle_after) begin
                // Request was still high in DONE; dropping it now must leave the FSM idle.
                wr_en = 1'b0; rd_en = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d no retrigger ready", i), {31'b0, ready}, 32'd1);
                chk($sformatf("v%0d no retrigger we_n", i), {31'b0, sram_we_n}, 32'd1);
                chk($sformatf("v%0d no retrigger oe_n", i), {31'b0, sram_oe_n}, 32'd1);
                @(posedge clk); #1;
            end
        end

        // Reset during the fourth cycle of LOW of a write.
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'hAAAA5555;
        repeat (5) @(negedge clk);
        chk("mid write we_n", {31'b0, sram_we_n}, 32'd0);
        chk("mid write addr", {14'b0, sram_addr}, 32'd8);
        rst = 1'b1; wr_en = 1'b0;
        #1;
        chk("async rst we_n", {31'b0, sram_we_n}, 32'd1);
        chk("async rst oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("async rst addr", {14'b0, sram_addr}, 32'd0);
        chk("async rst ready", {31'b0, ready}, 32'd1);
        chk("async rst read_data", read_data, 32'd0);
        chk("partial write kept", {16'b0, mem[8]}, 32'h5555);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, lat, we_lo, oe_lo, rdat);
        chk("post-reset latency", 32'(lat), 32'd11);
        chk("post-reset read_data", rdat, 32'hDEADBEEF);
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the off-chip 16-bit SRAM on behalf of the ARM pipeline's MEM stage. It turns a single 32-bit load/store request into two timed 16-bit SRAM accesses. While an access is in progress it holds `ready` low so the pipeline top can freeze all stages. It sits between the MEM stage (address from EXE, `MEM_R_EN`/`MEM_W_EN` from the MEM pipeline register) and the SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: clock cycles each 16-bit half-access occupies (≥2).
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request; held by the frozen pipeline until `ready`.
- `rd_en` in 1: load request; held until `ready`.
- `address` in 32: byte address from the EXE result.
- `write_data` in 32: store data.
- `read_data` out 32: load result; valid when `ready` is high in DONE.
- `ready` out 1: high when no access is pending or the access completes this cycle.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: active-low write enable.
- `SRAM_OE_N` out 1: active-low output enable.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, truncated to 17 bits. Low half is at `{w,1'b0}`; high half is at `{w,1'b1}`.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `wr_en|rd_en`, latch `w`, `write_data`, and op into registers, then go to LOW.
  - `wr_en` wins if both are asserted.
- LOW and HIGH:
  - Each state lasts exactly `WAIT_CYCLES` cycles, counted by a counter that is cleared on state entry.
  - `SRAM_ADDR` is driven with the latched half address.
- Write:
  - `SRAM_DQ` is driven with `write_data[15:0]` in LOW and `[31:16]` in HIGH.
  - `SRAM_WE_N=0` for counts 0..`WAIT_CYCLES-2`, then 1 on the final count (data hold).
  - `SRAM_OE_N=1`.
- Read:
  - `SRAM_DQ` is high-Z, `SRAM_OE_N=0`, `SRAM_WE_N=1`.
  - On the final count of LOW, sample `SRAM_DQ` into `read_data[15:0]`; on the final count of HIGH, sample it into `[31:16]`.
- DONE: `ready=1` for one cycle, then go unconditionally to IDLE. A request still asserted in DONE is the completing one and must not retrigger.
- `ready` (combinational):
  - IDLE: `~(wr_en|rd_en)`.
  - LOW/HIGH: 0.
  - DONE: 1.
- Outside LOW/HIGH: `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ` high-Z, `SRAM_ADDR` = 0.
- `read_data` holds its last value until overwritten. Writes do not modify it.

## Timing
- Request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE (`ready=1`) is cycle 2W+1. For W=5 this is cycle 11.
- Freeze length: 2W+1 cycles with `ready` low (IDLE-with-request cycle plus LOW and HIGH).
- Back-to-back requests: IDLE is re-entered at cycle 2W+2; a request present then starts a new access.
- Request dropped mid-access (e.g. flush): the access still completes; inputs are ignored after the latch.
- Reset values, async, at any time including mid-access:
  - State IDLE, counter 0, `read_data=0`.
  - `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ` high-Z, `SRAM_ADDR=0`.
  - `ready = ~(wr_en|rd_en)`.
- A partial write interrupted by reset is not rolled back.

## Structure
- Shared package `sram_pkg`: state encoding (IDLE=0, LOW=1, HIGH=2, DONE=3), default `WAIT_CYCLES`, `BASE_ADDR`, SRAM address/data widths (18/16).
- One sub-module: `sram_wait_counter` (clear, enable, `last` flag at `WAIT_CYCLES-1`).
- FSM, latches and pin drivers stay in `sram_controller`.
- Pipeline top computes `freeze = (MEM_R_EN|MEM_W_EN) & ~ready`.

## Test plan
- Reset, no requests → `ready=1`, `SRAM_WE_N=1`, `SRAM_OE_N=1`, DQ high-Z, `read_data=0`.
- Write `address=1028`, `write_data=32'hDEAD_BEEF`, W=5 → SRAM model holds `[2]=16'hBEEF` and `[3]=16'hDEAD`. `ready` is low for cycles 0..10 and high at cycle 11. `SRAM_WE_N` pulses low for 4 cycles per half.
- Read back `address=1028` → `read_data=32'hDEADBEEF` exactly in the DONE cycle (11 cycles after the request).
- Back-to-back write then read of `address=1024`: the second access starts in the cycle after DONE. No extra access is started in DONE.
- `rd_en` and `wr_en` both asserted → a write is performed, and `read_data` is unchanged.
- Assert `rst` at cycle 3 of LOW during a write → outputs return to reset values immediately. The next request restarts from IDLE with a full 11-cycle latency.
